// File: rtl/round_key_scheduler_pkg.sv
// Shared AES definitions for the sequential key scheduler: byte/word/round-key
// types, the forward S-box, round constants and the scheduler state encoding.
package round_key_scheduler_pkg;

    localparam int unsigned AES_STATE_SIZE = 16;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:3] word_t;
    typedef byte_t [0:AES_STATE_SIZE-1] roundKey_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants; index 0 is unused by the schedule.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } sched_state_e;

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TABLE[b];
    endfunction

endpackage

// File: rtl/round_key_scheduler_transform.sv
// key_word_transform: combinational term generator for one schedule word.
//   prev_word : w[i-1]
//   word_mod  : i mod NK
//   rcon_idx  : i / NK (values above 10 yield a zero round constant)
//   nk_is_8   : AES-256 schedule, enables the mid-block SubWord
//   term_c    : t, to be XORed with w[i-NK]
module key_word_transform
    import round_key_scheduler_pkg::*;
(
    input  word_t       prev_word,
    input  logic [2:0]  word_mod,
    input  logic [3:0]  rcon_idx,
    input  logic        nk_is_8,
    output word_t       term_c
);

    word_t sub_word;
    word_t rot_sub_word;
    byte_t rcon_byte;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sub_word[k] = sbox(prev_word[k]);
        end
        // SubWord is byte-wise, so rotating after substitution is equivalent.
        rot_sub_word = {sub_word[1], sub_word[2], sub_word[3], sub_word[0]};
        rcon_byte    = (rcon_idx <= 4'd10) ? RCON[rcon_idx] : 8'h00;

        term_c = prev_word;
        if (word_mod == 3'd0) begin
            term_c = rot_sub_word ^ {rcon_byte, 24'h000000};
        end else if (nk_is_8 && (word_mod == 3'd4)) begin
            term_c = sub_word;
        end
    end

endmodule

// File: rtl/round_key_scheduler.sv
// round_key_scheduler: iterative AES key expansion, one word per clock, with a
// registered indexed round-key read port.
//   clock, reset           : rising-edge clock, async active-high reset
//   key, key_valid/ready   : cipher key handshake (accepted in IDLE or READY)
//   keys_valid             : full schedule stored and readable
//   rk_req, rk_index       : round-key read request (ignored until keys_valid)
//   rk_valid, round_key    : one-cycle response pulse with w[4r..4r+3]
module round_key_scheduler
    import round_key_scheduler_pkg::*;
#(
    parameter int unsigned KEY_SIZE   = 128,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_BYTES  = KEY_SIZE / 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  byte_t [0:KEY_BYTES-1]      key,
    input  logic                       key_valid,
    output logic                       key_ready,
    output logic                       keys_valid,
    input  logic                       rk_req,
    input  logic [3:0]                 rk_index,
    output logic                       rk_valid,
    output roundKey_t                  round_key
);

    localparam int unsigned NK          = KEY_SIZE / 32;
    localparam int unsigned TOTAL_WORDS = 4 * (NUM_ROUNDS + 1);
    localparam int unsigned IDX_W       = 6;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    word_t            w_q      [TOTAL_WORDS];
    word_t            w_d      [TOTAL_WORDS];
    word_t            window_q [NK];
    word_t            window_d [NK];
    logic             key_ready_q, key_ready_d;
    logic             keys_valid_q, keys_valid_d;
    logic             rk_valid_q, rk_valid_d;
    roundKey_t        round_key_q, round_key_d;

    logic [KEY_SIZE-1:0] key_flat;
    logic                key_accept;
    logic                rk_accept;
    logic [2:0]          word_mod;
    logic [3:0]          rcon_idx;
    word_t               term;
    word_t               new_word;
    logic [3:0]          rd_round;
    logic [IDX_W-1:0]    rd_base;

    assign key_flat = key;
    assign word_mod = 3'(i_q % IDX_W'(NK));
    assign rcon_idx = 4'(i_q / IDX_W'(NK));

    // window_q[NK-1] is w[i-1], window_q[0] is w[i-NK].
    key_word_transform u_transform (
        .prev_word (window_q[NK-1]),
        .word_mod  (word_mod),
        .rcon_idx  (rcon_idx),
        .nk_is_8   (NK == 8),
        .term_c    (term)
    );

    assign new_word   = window_q[0] ^ term;
    assign key_accept = key_valid && key_ready_q;
    // A key load in the same cycle takes priority over a read.
    assign rk_accept  = rk_req && keys_valid_q && !key_accept;
    assign rd_round   = (rk_index > 4'(NUM_ROUNDS)) ? 4'd0 : rk_index;
    assign rd_base    = {rd_round, 2'b00};

    // Next-state, schedule storage and read-port logic.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        w_d         = w_q;
        window_d    = window_q;
        rk_valid_d  = 1'b0;
        round_key_d = round_key_q;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_accept) begin
                    for (int unsigned k = 0; k < NK; k++) begin
                        w_d[k]      = key_flat[KEY_SIZE-1-32*k -: 32];
                        window_d[k] = key_flat[KEY_SIZE-1-32*k -: 32];
                    end
                    i_d     = IDX_W'(NK);
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = new_word;
                for (int unsigned k = 0; k + 1 < NK; k++) begin
                    window_d[k] = window_q[k+1];
                end
                window_d[NK-1] = new_word;
                i_d            = i_q + IDX_W'(1);
                if (i_q == IDX_W'(TOTAL_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rk_accept) begin
            rk_valid_d = 1'b1;
            if (rk_index > 4'(NUM_ROUNDS)) begin
                round_key_d = '0;
            end else begin
                round_key_d = {w_q[rd_base], w_q[rd_base + IDX_W'(1)],
                               w_q[rd_base + IDX_W'(2)], w_q[rd_base + IDX_W'(3)]};
            end
        end

        key_ready_d  = (state_d != ST_EXPAND);
        keys_valid_d = (state_d == ST_READY);
    end

    // Control and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            key_ready_q  <= 1'b1;
            keys_valid_q <= 1'b0;
            rk_valid_q   <= 1'b0;
            round_key_q  <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            key_ready_q  <= key_ready_d;
            keys_valid_q <= keys_valid_d;
            rk_valid_q   <= rk_valid_d;
            round_key_q  <= round_key_d;
        end
    end

    // Schedule storage is never cleared; keys_valid gates its visibility.
    always_ff @(posedge clock) begin
        w_q      <= w_d;
        window_q <= window_d;
    end

    assign key_ready  = key_ready_q;
    assign keys_valid = keys_valid_q;
    assign rk_valid   = rk_valid_q;
    assign round_key  = round_key_q;

endmodule

// File: tb/tb_round_key_scheduler.sv
// Directed bench for round_key_scheduler: AES-128/192/256 expansions against
// FIPS-197 vectors, latency, read-port gating, async reset and rekeying.
module tb_round_key_scheduler;
    import round_key_scheduler_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic [127:0] key_a;
    logic [191:0] key_b;
    logic [255:0] key_c;
    logic kv_a, kv_b, kv_c;
    logic kr_a, kr_b, kr_c;
    logic ksv_a, ksv_b, ksv_c;
    logic req_a, req_b, req_c;
    logic [3:0] idx_a, idx_b, idx_c;
    logic rv_a, rv_b, rv_c;
    roundKey_t rk_a, rk_b, rk_c;

    int n_checks = 0;
    int n_fail   = 0;

    round_key_scheduler #(.KEY_SIZE(128), .NUM_ROUNDS(10)) u_dut_a (
        .clock(clock), .reset(reset), .key(key_a), .key_valid(kv_a),
        .key_ready(kr_a), .keys_valid(ksv_a), .rk_req(req_a),
        .rk_index(idx_a), .rk_valid(rv_a), .round_key(rk_a)
    );

    round_key_scheduler #(.KEY_SIZE(192), .NUM_ROUNDS(12)) u_dut_b (
        .clock(clock), .reset(reset), .key(key_b), .key_valid(kv_b),
        .key_ready(kr_b), .keys_valid(ksv_b), .rk_req(req_b),
        .rk_index(idx_b), .rk_valid(rv_b), .round_key(rk_b)
    );

    round_key_scheduler #(.KEY_SIZE(256), .NUM_ROUNDS(14)) u_dut_c (
        .clock(clock), .reset(reset), .key(key_c), .key_valid(kv_c),
        .key_ready(kr_c), .keys_valid(ksv_c), .rk_req(req_c),
        .rk_index(idx_c), .rk_valid(rv_c), .round_key(rk_c)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle read on instance a/b/c; returns the response sampled after the edge.
    task automatic read_rk(input int inst, input logic [3:0] idx,
                           output logic v, output logic [127:0] rk);
        case (inst)
            0: begin idx_a = idx; req_a = 1'b1; end
            1: begin idx_b = idx; req_b = 1'b1; end
            default: begin idx_c = idx; req_c = 1'b1; end
        endcase
        tick();
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        case (inst)
            0: begin v = rv_a; rk = rk_a; end
            1: begin v = rv_b; rk = rk_b; end
            default: begin v = rv_c; rk = rk_c; end
        endcase
    endtask

    // Edges until keys_valid on instance a, 0 if it never rises within budget.
    task automatic wait_ready_a(output int edges);
        edges = 0;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (ksv_a) begin
                edges = n;
                break;
            end
        end
    endtask

    logic         v;
    logic [127:0] rk;
    int           e_a, e_b, e_c, e;
    logic         saw_rv;

    initial begin
        reset = 1'b1;
        key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_b = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key_c = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        kv_a = 1'b0; kv_b = 1'b0; kv_c = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        idx_a = '0; idx_b = '0; idx_c = '0;
        tick();

        check("rst_key_ready", kr_a, 1'b1);
        check("rst_keys_valid", ksv_a, 1'b0);
        check("rst_rk_valid", rv_a, 1'b0);
        check("rst_round_key", rk_a, 128'h0);

        // Load all three keys on the same edge; a read is held pending on a.
        reset = 1'b0;
        kv_a = 1'b1; kv_b = 1'b1; kv_c = 1'b1;
        req_a = 1'b1; idx_a = 4'd10;
        tick();
        kv_a = 1'b0; kv_b = 1'b0; kv_c = 1'b0;
        check("busy_key_ready", kr_a, 1'b0);

        e_a = 0; e_b = 0; e_c = 0;
        saw_rv = rv_a;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (e_a == 0 && rv_a) saw_rv = 1'b1;
            if (ksv_a && e_a == 0) begin e_a = n; req_a = 1'b0; end
            if (ksv_b && e_b == 0) e_b = n;
            if (ksv_c && e_c == 0) e_c = n;
        end
        check("latency_128", 128'(e_a), 128'd40);
        check("latency_192", 128'(e_b), 128'd46);
        check("latency_256", 128'(e_c), 128'd52);
        check("no_rv_in_expand", saw_rv, 1'b0);
        check("ready_key_ready", kr_a, 1'b1);

        // Back-to-back reads then a single-cycle pulse check.
        idx_a = 4'd0; req_a = 1'b1;
        tick();
        check("rd0_valid_128", rv_a, 1'b1);
        check("rd0_key_128", rk_a, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        idx_a = 4'd10;
        tick();
        req_a = 1'b0;
        check("rd10_valid_128", rv_a, 1'b1);
        check("rd10_key_128", rk_a, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        check("rv_pulse", rv_a, 1'b0);

        read_rk(0, 4'd1, v, rk);
        check("rd1_key_128", rk, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(0, 4'd15, v, rk);
        check("rd15_valid", v, 1'b1);
        check("rd15_zero", rk, 128'h0);

        read_rk(1, 4'd12, v, rk);
        check("rd12_valid_192", v, 1'b1);
        check("rd12_key_192", rk, 128'he98ba06f448c773c8ecc720401002202);
        read_rk(1, 4'd1, v, rk);
        check("rd1_key_192", rk, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);

        read_rk(2, 4'd14, v, rk);
        check("rd14_valid_256", v, 1'b1);
        check("rd14_key_256", rk, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(2, 4'd0, v, rk);
        check("rd0_key_256", rk, 128'h603deb1015ca71be2b73aef0857d7781);
        read_rk(2, 4'd1, v, rk);
        check("rd1_key_256", rk, 128'h1f352c073b6108d72d9810a30914dff4);

        // Reset 20 edges into a fresh AES-128 expansion.
        kv_a = 1'b1;
        tick();
        kv_a = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        #1;
        check("midrst_key_ready", kr_a, 1'b1);
        check("midrst_keys_valid", ksv_a, 1'b0);
        check("midrst_rk_valid", rv_a, 1'b0);
        #1;
        reset = 1'b0;
        read_rk(0, 4'd10, v, rk);
        check("idle_read_ignored", v, 1'b0);

        kv_a = 1'b1;
        tick();
        kv_a = 1'b0;
        wait_ready_a(e);
        check("latency_reload", 128'(e), 128'd40);
        read_rk(0, 4'd10, v, rk);
        check("reload_rd10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Rekey in READY with a concurrent read: the load wins.
        key_a = 128'h000102030405060708090a0b0c0d0e0f;
        kv_a = 1'b1; req_a = 1'b1; idx_a = 4'd0;
        tick();
        kv_a = 1'b0; req_a = 1'b0;
        check("rekey_rd_dropped", rv_a, 1'b0);
        check("rekey_keys_valid", ksv_a, 1'b0);
        check("rekey_key_ready", kr_a, 1'b0);
        wait_ready_a(e);
        check("latency_rekey", 128'(e), 128'd40);
        read_rk(0, 4'd10, v, rk);
        check("rekey_rd10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_rk(0, 4'd1, v, rk);
        check("rekey_rd1", rk, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_key_scheduler.md
# round_key_scheduler

Sequential AES key-schedule engine. It accepts a cipher key over a valid/ready handshake and expands it iteratively, one 32-bit schedule word per clock, into an internal round-key store. It then serves 128-bit round keys by index to the encoder/decoder round pipeline. It replaces the fully combinational, all-rounds-at-once expansion path wherever area matters more than key-change latency.

## Interface
- KEY_SIZE, 128, cipher key width in bits: 128, 192 or 256.
- NUM_ROUNDS, 10, cipher rounds: 10, 12 or 14, paired with KEY_SIZE by the instantiating encoder/decoder.
- KEY_BYTES, KEY_SIZE/8, key width in bytes.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- key  in  byte_t[0:KEY_BYTES-1]  cipher key; byte 0 is the most significant byte of word w0.
- key_valid  in  1  key is presented.
- key_ready  out  1  block can accept a key; high in IDLE and READY.
- keys_valid  out  1  the full schedule is stored and readable.
- rk_req  in  1  round-key read request.
- rk_index  in  4  round number, 0..NUM_ROUNDS.
- rk_valid  out  1  round_key holds the response to the previous accepted request.
- round_key  out  roundKey_t  words w[4r..4r+3]; byte 0 is the most significant byte of w[4r].

## Operation
- NK = KEY_SIZE/32. TOTAL_WORDS = 4*(NUM_ROUNDS+1), which is 44, 52 or 60.
- Storage: a word array w[0:TOTAL_WORDS-1] plus a shift window holding the last NK words.
- FSM states:
  - IDLE: key_ready=1, keys_valid=0. On key_valid&&key_ready, store w[0..NK-1]=key, load the window, set i=NK, go to EXPAND.
  - EXPAND: key_ready=0. Each cycle computes w[i]=w[i-NK]^t and sets i=i+1. When the last word w[TOTAL_WORDS-1] is written, go to READY.
  - READY: key_ready=1, keys_valid=1. A new key_valid triggers the same load as IDLE, clears keys_valid and goes to EXPAND.
- Term t for word i:
  - i mod NK==0: t=SubWord(RotWord(w[i-1]))^{Rcon[i/NK],00,00,00}.
  - NK==8 and i mod 8==4: t=SubWord(w[i-1]).
  - Otherwise: t=w[i-1].
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord applies the shared sbox to each byte. RotWord moves byte 0 to byte 3.
- Read port:
  - rk_req is accepted only when keys_valid=1; otherwise it is ignored and rk_valid stays 0.
  - An accepted request with rk_index>NUM_ROUNDS returns round_key=0 with rk_valid=1.
  - Decrypt ordering is the requester's job (index NUM_ROUNDS down to 0); no reversal is done here.
- The counter i is 6 bits wide. Rcon index i/NK never exceeds 10.

## Timing
- Reset values (async, immediate): state IDLE, key_ready=1, keys_valid=0, rk_valid=0, round_key=0, i=0. Storage is not cleared.
- Expansion latency: keys_valid rises TOTAL_WORDS-NK edges after the accept edge, i.e. 40, 46 or 52 edges.
- Read latency: 1 cycle. rk_valid and round_key are registered on the edge after the accepting edge. rk_valid is a single-cycle pulse per request, and back-to-back requests give back-to-back responses.
- Key accepted in READY in the same cycle as rk_req: the key load wins and the read is dropped (rk_valid=0 next cycle).
- key_valid held high continuously: exactly one key is loaded per ready window. A second key is loaded only on re-entering READY.
- reset asserted mid-EXPAND: returns to IDLE at once. The partial schedule is never exposed because keys_valid is 0.

## Structure
- AESDefinitions package: byte_t, roundKey_t, sbox, AES_STATE_SIZE. Add typedef word_t (byte_t[0:3]), RCON word constant, and scheduler state enum.
- One sub-module: key_word_transform, combinational RotWord/SubWord/Rcon term generator taking w[i-1], i mod NK, Rcon index and NK==8. It is verified standalone.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid after 40 edges; rk_index 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rk_index 0 -> the key.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> keys_valid after 46 edges; rk_index 12 -> e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> keys_valid after 52 edges; rk_index 14 -> fe4890d1e6188d0b046df344706c631e.
- rk_req during EXPAND, and rk_index=15 in READY -> no rk_valid in EXPAND; zero key with rk_valid=1 in READY.
- reset asserted at edge 20 of an AES-128 expansion, then key reloaded -> key_ready=1 immediately, keys_valid=0; after reload, the round-10 key is correct.
- Rekey in READY concurrent with rk_req -> rk_valid=0 next cycle, keys_valid drops, new schedule correct.
